bpsk_frame_sequencer: RTL and testbench
=======================================

Name: bpsk_frame_sequencer

Overview:
Frame-timing controller for the BPSK transmit chain. On a start request it sequences one frame through four phases: preamble, payload, convolutional-code tail and inter-frame gap. It generates the per-symbol sample index, bit index, symbol strobes and the payload-bit request handshake to the upstream bit source. The modulator/upsampler consumes its tx_bit and sample index directly.

Parameters:
SPS, 8, samples (clocks) per bit; must be >= 2.
PRE_LEN, 32, preamble length in bits; pattern is alternating, starting with 1 (1,0,1,0,...).
PAY_LEN, 2048, payload length in bits.
TAIL_LEN, 6, zero flush bits for the encoder (K-1).
GAP_LEN, 16, idle bits between frames.

Ports:
clk_sig  in  1  system clock; all logic on the rising edge.
reset_sig  in  1  asynchronous reset, active-low.
start_sig  in  1  frame request; level-sampled only in IDLE.
data_in_sig  in  1  payload bit from upstream.
data_vld_sig  in  1  data_in_sig valid; sampled only when data_req_sig=1.
data_req_sig  out  1  request next payload bit this cycle.
tx_bit_sig  out  1  bit currently on air; held for SPS cycles.
sample_idx_sig  out  $clog2(SPS)  sample index 0..SPS-1 within the current bit.
bit_idx_sig  out  $clog2(MAXLEN)  bit index within the current phase; MAXLEN = max(PRE_LEN,PAY_LEN,TAIL_LEN,GAP_LEN).
phase_sig  out  2  0 IDLE/GAP, 1 PRE, 2 PAY, 3 TAIL.
sym_start_sig  out  1  high on sample 0 of every PRE/PAY/TAIL bit.
busy_sig  out  1  high in PRE, PAY, TAIL and GAP.
frame_done_sig  out  1  one-cycle pulse on the first GAP cycle.
underrun_sig  out  1  sticky; set on a payload request with data_vld_sig=0; cleared on accepted start.

Behaviour:
- Reset (async assert, synchronous-release tolerant): state IDLE, all outputs and counters 0, underrun cleared. Reset mid-frame aborts the frame immediately with no done pulse.
- FSM states: IDLE, PRE, PAY, TAIL, GAP. All outputs are registered, except data_req_sig, which is decoded from registered state only and has no input dependence.
- IDLE: start_sig=1 at an edge moves to PRE next cycle. First PRE cycle: sample_idx=0, bit_idx=0, tx_bit=1, sym_start=1. Underrun is cleared on that same edge.
- Counting: sample_idx increments every cycle and wraps SPS-1 -> 0. bit_idx increments on each wrap. At the wrap of bit LEN-1 of a phase, bit_idx resets to 0 and the phase advances: PRE->PAY->TAIL->GAP->IDLE.
- PRE: tx_bit = NOT bit_idx[0].
- data_req_sig: high during the last sample (sample_idx=SPS-1) of the bit preceding every payload bit. That is the last PRE bit and payload bits 0..PAY_LEN-2, giving exactly PAY_LEN requests per frame. At that edge:
  - data_vld=1: tx_bit <= data_in.
  - data_vld=0: tx_bit <= 0 and underrun <= 1.
- TAIL and GAP: tx_bit=0. GAP has no sym_start. busy stays 1 through GAP.
- frame_done_sig pulses on the cycle phase first reads GAP.
- GAP->IDLE: busy drops on the first IDLE cycle. Back-to-back frames therefore have a minimum of one IDLE cycle after GAP.
- start_sig while busy is ignored, not queued. start held high continuously produces repeated frames.
- Total frame from start edge: (PRE_LEN+PAY_LEN+TAIL_LEN+GAP_LEN)*SPS busy cycles.
- Widths: counter compares use full-width constants LEN-1. Parameters are lengths >= 1, so no zero-length phases.

Decomposition:
- Package bpsk_frame_pkg: phase encodings (PH_IDLE=0, PH_PRE=1, PH_PAY=2, PH_TAIL=3) and the FSM state enum.
- One sub-module, frame_counter: parameterised modulus, enable, synchronous clear, wrap flag, async active-low reset. Instantiated once for samples and once for bits.

Test Plan (SPS=4, PRE_LEN=4, PAY_LEN=8, TAIL_LEN=2, GAP_LEN=2; start edge = cycle 0):
1. start pulse at cycle 0 -> phase=1 from cycle 1; tx_bit 1,0,1,0 each held 4 cycles (cycles 1-16); sym_start at 1,5,9,13; data_req first high at cycle 16.
2. Upstream supplies 0xA5 LSB-first with vld=1 -> tx_bit 1,0,1,0,0,1,0,1 over cycles 17-48; exactly 8 data_req pulses; underrun stays 0.
3. vld=0 on the request for payload bit 3 -> tx_bit=0 for cycles 29-32; underrun=1 from cycle 29 and held through the frame; next accepted start clears it.
4. Frame end -> TAIL cycles 49-56 with tx_bit=0; frame_done single pulse at cycle 57; GAP cycles 57-64; busy=0 and phase=0 at cycle 65.
5. start held high throughout -> pulses during cycles 1-64 ignored; second frame phase=1 at cycle 66.
6. reset_sig low mid-payload (between edges) -> all outputs 0 immediately without a clock edge, no done pulse; after release, block stays IDLE until start.

Source files
------------

// File: rtl/bpsk_frame_pkg.sv
// bpsk_frame_pkg: phase encodings and FSM state type for the BPSK frame sequencer
package bpsk_frame_pkg;
  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_PRE  = 2'd1;
  localparam logic [1:0] PH_PAY  = 2'd2;
  localparam logic [1:0] PH_TAIL = 2'd3;
  typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_PAY, ST_TAIL, ST_GAP} state_e;
  function automatic logic [1:0] phase_of(input state_e s);
    return s == ST_PRE ? PH_PRE : s == ST_PAY ? PH_PAY : s == ST_TAIL ? PH_TAIL : PH_IDLE;
  endfunction
endpackage

// File: rtl/frame_counter.sv
// frame_counter: modulus counter with enable, sync clear, runtime terminal count and wrap flag
module frame_counter #(
  parameter int MOD = 8,
  parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk_sig,
  input  logic         reset_sig,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] top,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  assign wrap = en && cnt == top;
  always_ff @(posedge clk_sig or negedge reset_sig)
    if (!reset_sig) cnt <= '0;
    else cnt <= (clr || wrap) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/bpsk_frame_sequencer.sv
// bpsk_frame_sequencer: sequences preamble, payload, tail and gap timing for the BPSK transmitter
module bpsk_frame_sequencer
  import bpsk_frame_pkg::*;
#(
  parameter int SPS      = 8,
  parameter int PRE_LEN  = 32,
  parameter int PAY_LEN  = 2048,
  parameter int TAIL_LEN = 6,
  parameter int GAP_LEN  = 16,
  localparam int MAX_A   = PRE_LEN > PAY_LEN ? PRE_LEN : PAY_LEN,
  localparam int MAX_B   = TAIL_LEN > GAP_LEN ? TAIL_LEN : GAP_LEN,
  localparam int MAXLEN  = MAX_A > MAX_B ? MAX_A : MAX_B,
  localparam int SW      = $clog2(SPS),
  localparam int BW      = MAXLEN > 1 ? $clog2(MAXLEN) : 1
) (
  input  logic          clk_sig,
  input  logic          reset_sig,
  input  logic          start_sig,
  input  logic          data_in_sig,
  input  logic          data_vld_sig,
  output logic          data_req_sig,
  output logic          tx_bit_sig,
  output logic [SW-1:0] sample_idx_sig,
  output logic [BW-1:0] bit_idx_sig,
  output logic [1:0]    phase_sig,
  output logic          sym_start_sig,
  output logic          busy_sig,
  output logic          frame_done_sig,
  output logic          underrun_sig
);
  localparam logic [SW-1:0] S_TOP    = SW'(SPS - 1);
  localparam logic [BW-1:0] PRE_TOP  = BW'(PRE_LEN - 1);
  localparam logic [BW-1:0] PAY_TOP  = BW'(PAY_LEN - 1);
  localparam logic [BW-1:0] TAIL_TOP = BW'(TAIL_LEN - 1);
  localparam logic [BW-1:0] GAP_TOP  = BW'(GAP_LEN - 1);
  state_e state, nxt;
  logic idle, s_wrap, b_wrap, tx_nxt, sym_nxt, done_nxt, und_nxt;
  logic [BW-1:0] b_top;
  assign idle      = state == ST_IDLE;
  assign busy_sig  = !idle;
  assign phase_sig = phase_of(state);
  assign b_top     = state == ST_PRE ? PRE_TOP : state == ST_PAY ? PAY_TOP : state == ST_TAIL ? TAIL_TOP : GAP_TOP;
  frame_counter #(.MOD(SPS), .W(SW)) u_sample (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .en(!idle), .clr(idle),
    .top(S_TOP), .cnt(sample_idx_sig), .wrap(s_wrap)
  );
  frame_counter #(.MOD(MAXLEN), .W(BW)) u_bit (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .en(s_wrap), .clr(idle),
    .top(b_top), .cnt(bit_idx_sig), .wrap(b_wrap)
  );
  always_ff @(posedge clk_sig or negedge reset_sig)
    if (!reset_sig) state <= ST_IDLE;
    else state <= nxt;
  always_comb
    nxt = idle ? (start_sig ? ST_PRE : ST_IDLE) : !b_wrap ? state : state == ST_GAP ? ST_IDLE : state_e'(state + 3'd1);
  always_comb begin
    data_req_sig = s_wrap && (state == ST_PRE ? bit_idx_sig == PRE_TOP : state == ST_PAY && bit_idx_sig != PAY_TOP);
    tx_nxt       = idle ? start_sig : data_req_sig ? data_vld_sig & data_in_sig : !s_wrap ? tx_bit_sig : state == ST_PRE && bit_idx_sig[0];
    sym_nxt      = (nxt == ST_PRE || nxt == ST_PAY || nxt == ST_TAIL) && (idle || s_wrap);
    done_nxt     = nxt == ST_GAP && state != ST_GAP;
    und_nxt      = idle ? underrun_sig && !start_sig : underrun_sig || (data_req_sig && !data_vld_sig);
  end
  always_ff @(posedge clk_sig or negedge reset_sig)
    if (!reset_sig) {tx_bit_sig, sym_start_sig, frame_done_sig, underrun_sig} <= '0;
    else {tx_bit_sig, sym_start_sig, frame_done_sig, underrun_sig} <= {tx_nxt, sym_nxt, done_nxt, und_nxt};
endmodule

// File: tb/tb_bpsk_frame_sequencer.sv
// tb_bpsk_frame_sequencer: table-driven and scoreboard checks of frame timing, payload, underrun and reset
module tb_bpsk_frame_sequencer;
  localparam int SPS = 4, PRE = 4, PAY = 8, TL = 2, GP = 2;
  logic clk_sig = 0, reset_sig = 0, start_sig = 0, data_in_sig = 0, data_vld_sig = 0;
  logic data_req_sig, tx_bit_sig, sym_start_sig, busy_sig, frame_done_sig, underrun_sig;
  logic [1:0] sample_idx_sig, phase_sig;
  logic [2:0] bit_idx_sig;
  int n_vec = 0, n_err = 0, c = 0, pidx = 0, drop = -1, req_cnt = 0, done_cnt = 0;
  logic [7:0] pay_byte = 8'hA5;
  logic e;
  logic q[$];
  typedef struct {int cyc; logic [12:0] exp;} vec_t;
  vec_t tbl[21];

  bpsk_frame_sequencer #(.SPS(SPS), .PRE_LEN(PRE), .PAY_LEN(PAY), .TAIL_LEN(TL), .GAP_LEN(GP)) dut (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .start_sig(start_sig), .data_in_sig(data_in_sig),
    .data_vld_sig(data_vld_sig), .data_req_sig(data_req_sig), .tx_bit_sig(tx_bit_sig),
    .sample_idx_sig(sample_idx_sig), .bit_idx_sig(bit_idx_sig), .phase_sig(phase_sig),
    .sym_start_sig(sym_start_sig), .busy_sig(busy_sig), .frame_done_sig(frame_done_sig),
    .underrun_sig(underrun_sig)
  );

  always #5 clk_sig = ~clk_sig;

  function automatic logic [12:0] outs();
    return {phase_sig, tx_bit_sig, sample_idx_sig, bit_idx_sig, sym_start_sig, busy_sig, frame_done_sig, data_req_sig, underrun_sig};
  endfunction

  function automatic vec_t mk(int cyc, int ph, int tx, int si, int bi, int sym, int bsy, int dn, int rq, int un);
    vec_t r;
    r.cyc = cyc;
    r.exp = {2'(ph), 1'(tx), 2'(si), 3'(bi), 1'(sym), 1'(bsy), 1'(dn), 1'(rq), 1'(un)};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, c, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_sig);
    c++;
  endtask

  task automatic go(input logic hold);
    start_sig = 1;
    c = 0;
    step();
    if (!hold) start_sig = 0;
  endtask

  task automatic run_to(input int cyc);
    while (c < cyc) step();
  endtask

  // upstream bit source and payload scoreboard
  always @(negedge clk_sig) begin
    if (frame_done_sig) done_cnt++;
    if (phase_sig == 2'd2 && sym_start_sig) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL payload_bit: tx=%0b with no bit expected", tx_bit_sig);
      end else begin
        e = q.pop_front();
        if (tx_bit_sig !== e) begin
          n_err++;
          $display("FAIL payload_bit %0d: got %0b expected %0b", bit_idx_sig, tx_bit_sig, e);
        end
      end
    end
    if (phase_sig == 2'd1 && sym_start_sig && bit_idx_sig == 3'd0) pidx = 0;
    if (data_req_sig) begin
      data_in_sig  = pay_byte[pidx[2:0]];
      data_vld_sig = pidx != drop;
      q.push_back(data_vld_sig & data_in_sig);
      pidx++;
      req_cnt++;
    end else begin
      data_in_sig  = 1'($urandom_range(0, 1));
      data_vld_sig = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl = '{
      mk(1, 1,1,0,0,1,1,0,0,0), mk(4, 1,1,3,0,0,1,0,0,0), mk(5, 1,0,0,1,1,1,0,0,0),
      mk(9, 1,1,0,2,1,1,0,0,0), mk(13,1,0,0,3,1,1,0,0,0), mk(16,1,0,3,3,0,1,0,1,0),
      mk(17,2,1,0,0,1,1,0,0,0), mk(20,2,1,3,0,0,1,0,1,0), mk(21,2,0,0,1,1,1,0,0,0),
      mk(25,2,1,0,2,1,1,0,0,0), mk(33,2,0,0,4,1,1,0,0,0), mk(37,2,1,0,5,1,1,0,0,0),
      mk(48,2,1,3,7,0,1,0,0,0), mk(49,3,0,0,0,1,1,0,0,0), mk(53,3,0,0,1,1,1,0,0,0),
      mk(56,3,0,3,1,0,1,0,0,0), mk(57,0,0,0,0,0,1,1,0,0), mk(58,0,0,1,0,0,1,0,0,0),
      mk(61,0,0,0,1,0,1,0,0,0), mk(64,0,0,3,1,0,1,0,0,0), mk(65,0,0,0,0,0,0,0,0,0)
    };
    repeat (3) @(negedge clk_sig);
    chk("reset_state", 32'(outs()), 0);
    reset_sig = 1;
    repeat (3) step();
    chk("idle_no_start", 32'(outs()), 0);
    // frame 1: 0xA5, all valid
    go(0);
    foreach (tbl[k]) begin
      run_to(tbl[k].cyc);
      chk($sformatf("vec%0d", k), 32'(outs()), 32'(tbl[k].exp));
    end
    chk("f1_req_cnt", 32'(req_cnt), 8);
    chk("f1_queue_empty", 32'(q.size()), 0);
    // frame 2: 0x3C with payload bit 3 not valid
    pay_byte = 8'h3C;
    drop = 3;
    req_cnt = 0;
    go(0);
    run_to(28);
    chk("f2_und_before", 32'({tx_bit_sig, underrun_sig}), 32'b10);
    run_to(29);
    chk("f2_und_set", 32'({tx_bit_sig, underrun_sig}), 32'b01);
    run_to(32);
    chk("f2_und_bit_end", 32'({tx_bit_sig, underrun_sig}), 32'b01);
    run_to(33);
    chk("f2_bit4", 32'({tx_bit_sig, underrun_sig}), 32'b11);
    run_to(65);
    chk("f2_end_sticky", 32'({busy_sig, underrun_sig}), 32'b01);
    chk("f2_req_cnt", 32'(req_cnt), 8);
    // frame 3: start held high; underrun cleared by accepted start
    pay_byte = 8'h5A;
    drop = -1;
    done_cnt = 0;
    go(1);
    chk("f3_und_clear", 32'({phase_sig, underrun_sig}), 32'b010);
    run_to(30);
    chk("f3_ignore_start", 32'(phase_sig), 2);
    run_to(65);
    chk("f3_idle_gap", 32'({busy_sig, phase_sig}), 0);
    chk("f3_one_done", 32'(done_cnt), 1);
    run_to(66);
    chk("f4_restart", 32'({phase_sig, tx_bit_sig, sym_start_sig, sample_idx_sig}), 32'b0111_00);
    start_sig = 0;
    // frame 4 aborted by reset mid-payload, between clock edges
    run_to(95);
    chk("f4_mid_pay", 32'(phase_sig), 2);
    done_cnt = 0;
    #2 reset_sig = 0;
    #1 chk("async_reset", 32'(outs()), 0);
    #1 reset_sig = 1;
    q.delete();
    repeat (10) step();
    chk("post_reset_idle", 32'({busy_sig, phase_sig, tx_bit_sig, sym_start_sig}), 0);
    chk("post_reset_no_done", 32'(done_cnt), 0);
    // frame 5 after reset
    pay_byte = 8'hA5;
    go(0);
    chk("f5_first", 32'({phase_sig, tx_bit_sig, sym_start_sig, busy_sig}), 32'b01111);
    run_to(16);
    chk("f5_req", 32'(data_req_sig), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
